// File: rtl/tick_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tick_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } tick_mode_e;

    localparam int TICK_W_DEF = 20;

    // A divisor of zero has no meaningful period, so it behaves as divide-by-one.
    function automatic logic [31:0] sat_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: up-counter with terminal-count decode, run control and
// a pending divisor/mode slot that is promoted only at period boundaries.
module tick_chan
    import tick_pkg::*;
#(
    parameter int W       = TICK_W_DEF,
    parameter int DEF_DIV = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_div,
    input  logic         cfg_mode,
    input  logic         start,
    input  logic         stop,
    input  logic         sync,
    output logic         tick,
    output logic         active
);

    logic [W-1:0] count;
    logic [W-1:0] div;
    logic [W-1:0] div_pend;
    logic [W-1:0] nx_div;
    tick_mode_e   mode;
    tick_mode_e   mode_pend;
    tick_mode_e   nx_mode;
    logic         pend_v;
    logic         nx_pv;
    logic         terminal;
    logic         promote;

    // A write in the same cycle as a period boundary is promoted directly.
    always_comb begin
        terminal = active && (count == (div - W'(1)));
        nx_pv    = cfg_we || pend_v;
        nx_div   = cfg_we ? W'(sat_div(32'(cfg_div))) : div_pend;
        nx_mode  = cfg_we ? tick_mode_e'(cfg_mode) : mode_pend;
        promote  = nx_pv && (!active || start || stop || sync || terminal);
    end

    assign tick = terminal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            active    <= 1'b0;
            div       <= W'(DEF_DIV);
            mode      <= MODE_PERIODIC;
            div_pend  <= '0;
            mode_pend <= MODE_PERIODIC;
            pend_v    <= 1'b0;
        end else begin
            if (stop) begin
                active <= 1'b0;
                count  <= '0;
            end else if (start) begin
                active <= 1'b1;
                count  <= '0;
            end else if (active) begin
                if (sync || terminal) begin
                    count <= '0;
                end else begin
                    count <= count + W'(1);
                end
                // A tick shown alongside sync was still issued, so one-shot ends here.
                if (terminal && (mode == MODE_ONESHOT)) begin
                    active <= 1'b0;
                end
            end

            if (promote) begin
                div    <= nx_div;
                mode   <= nx_mode;
                pend_v <= 1'b0;
            end else if (cfg_we) begin
                div_pend  <= nx_div;
                mode_pend <= nx_mode;
                pend_v    <= 1'b1;
            end
        end
    end

    a_count_in_range: assert property (@(posedge clk) disable iff (!rst) count < div);

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: decodes the config address into
// per-channel write strobes and fans sync out to every channel.
module tick_gen_multi
    import tick_pkg::*;
#(
    parameter int  NCH     = 4,
    parameter int  W       = TICK_W_DEF,
    parameter int  DEF_DIV = 1_000_000,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic           cfg_mode,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] stop,
    input  logic           sync,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] active
);

    // Addresses at or above NCH match no channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic we_ch;

        assign we_ch = cfg_we && (int'(cfg_ch) == i);

        tick_chan #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .cfg_we   (we_ch),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .start    (start[i]),
            .stop     (stop[i]),
            .sync     (sync),
            .tick     (tick[i]),
            .active   (active[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: three channels, 8-bit divisors, default divisor 4.
module tb_tick_gen_multi;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int DEF = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [W-1:0]   cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] active;

    int n_cmp = 0;
    int n_bad = 0;

    tick_gen_multi #(
        .NCH     (NCH),
        .W       (W),
        .DEF_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .start    (start),
        .stop     (stop),
        .sync     (sync),
        .tick     (tick),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int dv, input logic md);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_div  = W'(dv);
        cfg_mode = md;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
        start = st;
        stop  = sp;
        step();
        start = '0;
        stop  = '0;
    endtask

    // Samples tick[ch] for n cycles into a bit mask; also flags ticks on other channels.
    task automatic run_mask(input int ch, input int n, output logic [31:0] m, output logic others);
        logic [NCH-1:0] omask;
        omask  = ~(NCH'(1) << ch);
        m      = '0;
        others = 1'b0;
        for (int k = 0; k < n; k++) begin
            m[k]   = tick[ch];
            others = others | ((tick & omask) != '0);
            step();
        end
    endtask

    logic [31:0] m;
    logic        oth;

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        start = '0; stop = '0; sync = 1'b0;

        // 1: reset and default-divisor periodic run
        repeat (5) step();
        check_val("rst_tick", 32'(tick), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        rst = 1'b1;
        step();
        pulse(3'b001, 3'b000);
        check_val("t1_active", 32'(active), 32'h1);
        run_mask(0, 16, m, oth);
        check_val("t1_ticks_div4", m, 32'h8888);

        // 2: one-shot on ch1
        cfg_write(1, 3, 1'b1);
        pulse(3'b010, 3'b000);
        run_mask(1, 24, m, oth);
        check_val("t2_oneshot_ticks", m, 32'h4);
        check_val("t2_ch1_inactive", 32'(active[1]), 32'h0);

        // 3: reload mid-period on ch0
        pulse(3'b000, 3'b001);
        check_val("t3_stopped", 32'(active[0]), 32'h0);
        cfg_write(0, 5, 1'b0);
        pulse(3'b001, 3'b000);
        step();
        cfg_write(0, 2, 1'b0);
        run_mask(0, 12, m, oth);
        check_val("t3_reload_ticks", m, 32'h554);

        // 4: start+stop together, then sync realign
        pulse(3'b001, 3'b001);
        check_val("t4_startstop_active", 32'(active[0]), 32'h0);
        check_val("t4_startstop_tick", 32'(tick[0]), 32'h0);
        cfg_write(0, 5, 1'b0);
        pulse(3'b001, 3'b000);
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        run_mask(0, 12, m, oth);
        check_val("t4_sync_ticks", m, 32'h210);
        check_val("t4_others_silent", 32'(oth), 32'h0);
        check_val("t4_ch2_inactive", 32'(active[2]), 32'h0);

        // 5: divisor 0, out-of-range address, async reset mid-run
        pulse(3'b000, 3'b001);
        cfg_write(0, 0, 1'b0);
        pulse(3'b001, 3'b000);
        run_mask(0, 8, m, oth);
        check_val("t5_div0_ticks", m, 32'hFF);
        cfg_write(NCH, 7, 1'b0);
        pulse(3'b100, 3'b000);
        run_mask(2, 8, m, oth);
        check_val("t5_badch_ch2_div", m, 32'h88);
        check_val("t5_ch0_still_div1", 32'(tick[0]), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_val("t5_async_tick", 32'(tick), 32'h0);
        check_val("t5_async_active", 32'(active), 32'h0);
        step();
        step();
        check_val("t5_held_tick", 32'(tick), 32'h0);
        rst = 1'b1;
        step();
        pulse(3'b001, 3'b000);
        run_mask(0, 8, m, oth);
        check_val("t5_post_rst_div", m, 32'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
